// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 Set-2 scancode constants, decode states and event type
package ps2_pkg;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_12 = 8'h12;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_FA = 8'hFA;
  localparam logic [7:0] SC_EE = 8'hEE;
  localparam logic [7:0] SC_FE = 8'hFE;
  localparam logic [7:0] SC_00 = 8'h00;
  localparam logic [7:0] SC_FC = 8'hFC;
  localparam logic [7:0] SC_FF = 8'hFF;

  // Remaining bytes of the Pause sequence after its leading E1.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_E0   = 3'd1,
    S_F0   = 3'd2,
    S_E0F0 = 3'd3,
    S_E1   = 3'd4
  } ps2_state_e;

  typedef struct packed {
    logic       pressed;
    logic       extended;
    logic [7:0] code;
  } ps2_event_t;

  function automatic logic is_error_byte(input logic [7:0] b);
    return (b == SC_00) || (b == SC_FC) || (b == SC_FF);
  endfunction

  function automatic logic is_response_byte(input logic [7:0] b);
    return (b == SC_AA) || (b == SC_FA) || (b == SC_EE) || (b == SC_FE);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - synchronous FIFO of completed key events
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  ps2_event_t push_data,
  input  logic       pop,
  output ps2_event_t pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  ps2_event_t    mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push;
  logic          do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees the head slot this cycle, so a push into a full FIFO is still taken.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ps2_event_encoder.sv
// rtl/ps2_event_encoder.sv - Set-2 scancode stream to paced toggle-format ps2_key word
module ps2_event_encoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        clr_overflow,
  output logic [10:0] ps2_key,
  output logic        overflow
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP_CYCLES - 1);

  ps2_state_e  state_q, state_d;
  logic [2:0]  skip_q, skip_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [10:0] key_q, key_d;
  logic        ovf_q, ovf_d;

  logic        emit;
  ps2_event_t  ev;
  ps2_event_t  head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        drop;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    ev      = '{pressed: 1'b1, extended: 1'b0, code: byte_data};
    if (byte_valid) begin
      if (is_error_byte(byte_data)) begin
        state_d = S_IDLE;
        skip_d  = 3'd0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (byte_data == SC_E0) begin
              state_d = S_E0;
            end else if (byte_data == SC_F0) begin
              state_d = S_F0;
            end else if (byte_data == SC_E1) begin
              state_d = S_E1;
              skip_d  = PAUSE_SKIP;
            end else if (!is_response_byte(byte_data)) begin
              emit = 1'b1;
            end
          end
          S_E0: begin
            if (byte_data == SC_F0) begin
              state_d = S_E0F0;
            end else begin
              state_d     = S_IDLE;
              emit        = (byte_data != SC_12);
              ev.extended = 1'b1;
            end
          end
          S_F0: begin
            state_d    = S_IDLE;
            emit       = (byte_data != SC_F0) && (byte_data != SC_E0);
            ev.pressed = 1'b0;
          end
          S_E0F0: begin
            state_d     = S_IDLE;
            emit        = (byte_data != SC_12);
            ev.pressed  = 1'b0;
            ev.extended = 1'b1;
          end
          S_E1: begin
            // Pause is swallowed whole; it never produces an event.
            skip_d = (skip_q == 3'd0) ? 3'd0 : skip_q - 3'd1;
            if (skip_q <= 3'd1) state_d = S_IDLE;
          end
          default: begin
            state_d = S_IDLE;
            skip_d  = 3'd0;
          end
        endcase
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (emit),
    .push_data (ev),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pop  = !fifo_empty && (gap_q == '0);
  assign drop = emit && fifo_full && !pop;

  always_comb begin
    key_d = key_q;
    gap_d = gap_q;
    if (pop) begin
      key_d = {~key_q[10], head};
      gap_d = GAP_RELOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop)              ovf_d = 1'b1;
    else if (clr_overflow) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      skip_q  <= 3'd0;
      gap_q   <= '0;
      key_q   <= 11'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      gap_q   <= gap_d;
      key_q   <= key_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ps2_key  = key_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ps2_event_encoder.sv
// tb/tb_ps2_event_encoder.sv - directed bench for ps2_event_encoder
module tb_ps2_event_encoder;

  logic        clk;
  logic        reset_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        clr_overflow;
  logic [10:0] ps2_key;
  logic        overflow;

  int total;
  int bad;
  int tcount;
  logic prev_t;

  ps2_event_encoder #(
    .FIFO_DEPTH (4),
    .GAP_CYCLES (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .clr_overflow (clr_overflow),
    .ps2_key      (ps2_key),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (ps2_key[10] != prev_t) tcount++;
    prev_t = ps2_key[10];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n      = 1'b0;
    byte_valid   = 1'b0;
    clr_overflow = 1'b0;
    @(negedge clk);
    tcount = 0;
    prev_t = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    tcount = 0;
    prev_t = 1'b0;
    reset_n = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    clr_overflow = 1'b0;

    // 1: make, then break
    do_reset();
    check("rst_key", 32'(ps2_key), 32'h000);
    check("rst_ovf", 32'(overflow), 32'h0);
    send(8'h1C);
    check("t1_latency", 32'(ps2_key), 32'h000);
    idle(1);
    check("t1_make", 32'(ps2_key), 32'h61C);
    idle(20);
    send(8'hF0);
    send(8'h1C);
    idle(1);
    check("t1_break", 32'(ps2_key), 32'h01C);

    // 2: extended break then extended make
    do_reset();
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    idle(1);
    check("t2_ext_break", 32'(ps2_key), 32'h575);
    idle(20);
    send(8'hE0);
    send(8'h75);
    idle(1);
    check("t2_ext_make", 32'(ps2_key), 32'h375);

    // 3: burst overflows the 4-entry FIFO; events paced 16 cycles apart
    do_reset();
    for (int i = 0; i < 6; i++) send(8'h15 + 8'(i));
    check("t3_first", 32'(ps2_key), 32'h615);
    check("t3_ovf_set", 32'(overflow), 32'h1);
    idle(11);
    check("t3_hold15", 32'(ps2_key), 32'h615);
    idle(1);
    check("t3_out16", 32'(ps2_key), 32'h216);
    idle(15);
    check("t3_hold16", 32'(ps2_key), 32'h216);
    idle(1);
    check("t3_out17", 32'(ps2_key), 32'h617);
    idle(16);
    check("t3_out18", 32'(ps2_key), 32'h218);
    idle(16);
    check("t3_out19", 32'(ps2_key), 32'h619);
    idle(40);
    check("t3_no1A", 32'(ps2_key), 32'h619);
    check("t3_toggles", 32'(tcount), 32'd5);
    check("t3_ovf_sticky", 32'(overflow), 32'h1);
    clr_overflow = 1'b1;
    idle(1);
    clr_overflow = 1'b0;
    check("t3_ovf_clr", 32'(overflow), 32'h0);

    // 4: fake shift and Pause produce nothing
    do_reset();
    send(8'hE0); send(8'h12);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h16);
    idle(3);
    check("t4_key", 32'(ps2_key), 32'h616);
    check("t4_toggles", 32'(tcount), 32'd1);

    // 5: error byte cancels prefix; controller responses ignored
    do_reset();
    send(8'hE0); send(8'hFF); send(8'h75);
    idle(1);
    check("t5_err_clears", 32'(ps2_key), 32'h675);
    idle(20);
    send(8'hAA); send(8'hFA);
    idle(20);
    check("t5_resp_key", 32'(ps2_key), 32'h675);
    check("t5_resp_toggles", 32'(tcount), 32'd1);

    // 6: reset between prefix and code; async assert mid-cycle
    do_reset();
    send(8'h1C);
    idle(2);
    check("t6_pre", 32'(ps2_key), 32'h61C);
    send(8'hE0);
    reset_n = 1'b0;
    #1;
    check("t6_rst_key", 32'(ps2_key), 32'h000);
    @(negedge clk);
    reset_n = 1'b1;
    send(8'h75);
    idle(1);
    check("t6_after_rst", 32'(ps2_key), 32'h675);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_async", 32'(ps2_key), 32'h000);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
